iterative_shifter: RTL and testbench

- Parametrised multi-cycle shift/rotate unit for the datapath ALU; supersedes the fixed 32-bit single-mode combinational rotate-right.
- Supports logical right, arithmetic right, left shift, rotate right and rotate left by a variable amount.
- Shifts STEP bit positions per clock under a start/done handshake, so the control unit can sequence it like the multi-cycle mul/div units.

---
 rtl/iterative_shifter.sv | 123 ++++++++++++
 tb/tb_iterative_shifter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit. Moves the working value by up to STEP bit
// positions per clock and signals completion with a one-cycle done pulse.
//
// Ports:
//   clock_i    system clock, rising edge
//   clear_ni   asynchronous active-low reset; aborts any operation in flight
//   start_i    request pulse, only sampled in idle
//   mode_i     000 shr, 001 shra, 010 shl, 011 ror, 100 rol, 101-111 pass-through
//   operand_i  value to shift, captured on an accepted start
//   amount_i   shift count (0..WIDTH-1), captured on an accepted start
//   busy_o     high while shifting and during the done cycle
//   done_o     one-cycle pulse, result_o valid
//   result_o   shifted value, held until the next operation completes
module iterative_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AMT_W = 5,
   parameter int unsigned STEP  = 1
) (
   input  logic             clock_i,
   input  logic             clear_ni,
   input  logic             start_i,
   input  logic [2:0]       mode_i,
   input  logic [WIDTH-1:0] operand_i,
   input  logic [AMT_W-1:0] amount_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StShift = 2'b01,
      StDone  = 2'b10
   } state_e;

   // STEP <= WIDTH/2, so it always fits in the count width.
   localparam logic [AMT_W-1:0] StepAmt = AMT_W'(STEP);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;

   logic [AMT_W-1:0]   step_n;
   logic [WIDTH-1:0]   shifted;
   logic [2*WIDTH-1:0] rot_r, rot_l;

   // One step of the shifter: n = min(STEP, remaining).
   always_comb begin
      step_n = (cnt_q < StepAmt) ? cnt_q : StepAmt;
      // Rotates shift a doubled copy so wrapped bits come along for free.
      rot_r  = {work_q, work_q} >> step_n;
      rot_l  = {work_q, work_q} << step_n;
      unique case (mode_q)
         3'b000:  shifted = work_q >> step_n;
         3'b001:  shifted = $signed(work_q) >>> step_n;
         3'b010:  shifted = work_q << step_n;
         3'b011:  shifted = rot_r[WIDTH-1:0];
         3'b100:  shifted = rot_l[2*WIDTH-1:WIDTH];
         default: shifted = work_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               work_d = operand_i;
               cnt_d  = amount_i;
               mode_d = mode_i;
               // Zero count and pass-through modes have nothing to shift.
               if (amount_i == '0 || mode_i > 3'b100) begin
                  state_d  = StDone;
                  result_d = operand_i;
               end else begin
                  state_d = StShift;
               end
            end
         end
         StShift: begin
            work_d = shifted;
            cnt_d  = cnt_q - step_n;
            if (cnt_q == step_n) begin
               state_d  = StDone;
               result_d = shifted;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge clear_ni) begin
      if (!clear_ni) begin
         state_q  <= StIdle;
         work_q   <= '0;
         cnt_q    <= '0;
         mode_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         result_q <= result_d;
      end
   end

   assign busy_o   = (state_q != StIdle);
   assign done_o   = (state_q == StDone);
   assign result_o = result_q;

endmodule

// File: tb/tb_iterative_shifter.sv
module tb_iterative_shifter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clear_n;

   logic        s32, busy32, done32;
   logic [2:0]  m32;
   logic [31:0] op32, res32;
   logic [4:0]  a32;

   logic        s16, busy16, done16;
   logic [2:0]  m16;
   logic [15:0] op16, res16;
   logic [3:0]  a16;

   int n_tests = 0;
   int n_fail  = 0;

   iterative_shifter #(
      .WIDTH(32),
      .AMT_W(5),
      .STEP (1)
   ) u_dut32 (
      .clock_i  (clk),
      .clear_ni (clear_n),
      .start_i  (s32),
      .mode_i   (m32),
      .operand_i(op32),
      .amount_i (a32),
      .busy_o   (busy32),
      .done_o   (done32),
      .result_o (res32)
   );

   iterative_shifter #(
      .WIDTH(16),
      .AMT_W(4),
      .STEP (4)
   ) u_dut16 (
      .clock_i  (clk),
      .clear_ni (clear_n),
      .start_i  (s16),
      .mode_i   (m16),
      .operand_i(op16),
      .amount_i (a16),
      .busy_o   (busy16),
      .done_o   (done16),
      .result_o (res16)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: whole shift in one arithmetic step on a w-bit value.
   function automatic logic [31:0] ref_shift(input int w, input logic [2:0] m,
                                             input logic [31:0] v_in, input int a);
      logic [31:0] mask;
      logic [31:0] v;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      v    = v_in & mask;
      case (m)
         3'd0: return v >> a;
         3'd1: return v[w-1] ? ((v >> a) | (mask & ~(mask >> a))) : (v >> a);
         3'd2: return (v << a) & mask;
         3'd3: return ((v >> a) | (v << (w - a))) & mask;
         3'd4: return ((v << a) | (v >> (w - a))) & mask;
         default: return v;
      endcase
   endfunction

   // Edges from the one after start is driven up to the first done sample.
   function automatic int exp_lat(input logic [2:0] m, input int a, input int step);
      if (m > 3'd4 || a == 0) return 1;
      return (a + step - 1) / step + 1;
   endfunction

   task automatic do_op32(input logic [2:0] m, input logic [31:0] op, input logic [4:0] amt,
                          input int poke, output logic [31:0] res, output int lat,
                          output bit busy_ok, output bit post_ok);
      @(posedge clk); #1;
      s32 = 1'b1; m32 = m; op32 = op; a32 = amt;
      @(posedge clk); #1;
      s32 = 1'b0; lat = 1; busy_ok = 1'b1;
      m32 = ~m; op32 = ~op; a32 = ~amt;
      while (done32 !== 1'b1 && lat < 200) begin
         if (busy32 !== 1'b1) busy_ok = 1'b0;
         s32 = (lat == poke);
         @(posedge clk); #1;
         lat++;
      end
      s32 = 1'b0;
      if (busy32 !== 1'b1) busy_ok = 1'b0;
      res = res32;
      @(posedge clk); #1;
      post_ok = (done32 === 1'b0 && busy32 === 1'b0 && res32 === res);
   endtask

   task automatic do_op16(input logic [2:0] m, input logic [15:0] op, input logic [3:0] amt,
                          output logic [15:0] res, output int lat,
                          output bit busy_ok, output bit post_ok);
      @(posedge clk); #1;
      s16 = 1'b1; m16 = m; op16 = op; a16 = amt;
      @(posedge clk); #1;
      s16 = 1'b0; lat = 1; busy_ok = 1'b1;
      m16 = ~m; op16 = ~op; a16 = ~amt;
      while (done16 !== 1'b1 && lat < 200) begin
         if (busy16 !== 1'b1) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (busy16 !== 1'b1) busy_ok = 1'b0;
      res = res16;
      @(posedge clk); #1;
      post_ok = (done16 === 1'b0 && busy16 === 1'b0 && res16 === res);
   endtask

   task automatic run32(input string tag, input logic [2:0] m, input logic [31:0] op,
                        input logic [4:0] amt, input int poke);
      logic [31:0] res;
      int          lat;
      bit          busy_ok, post_ok;
      do_op32(m, op, amt, poke, res, lat, busy_ok, post_ok);
      check_eq({tag, "_res"}, res, ref_shift(32, m, op, int'(amt)));
      check_eq({tag, "_lat"}, lat, exp_lat(m, int'(amt), 1));
      check_eq({tag, "_busy"}, 32'(busy_ok), 32'd1);
      check_eq({tag, "_post"}, 32'(post_ok), 32'd1);
   endtask

   task automatic run16(input string tag, input logic [2:0] m, input logic [15:0] op,
                        input logic [3:0] amt);
      logic [15:0] res;
      int          lat;
      bit          busy_ok, post_ok;
      do_op16(m, op, amt, res, lat, busy_ok, post_ok);
      check_eq({tag, "_res"}, 32'(res), ref_shift(16, m, 32'(op), int'(amt)));
      check_eq({tag, "_lat"}, lat, exp_lat(m, int'(amt), 4));
      check_eq({tag, "_busy"}, 32'(busy_ok), 32'd1);
      check_eq({tag, "_post"}, 32'(post_ok), 32'd1);
   endtask

   initial begin
      logic [15:0] r16;
      int          l16, seen;
      bit          b16, p16;

      clear_n = 1'b0;
      s32 = 1'b0; m32 = '0; op32 = '0; a32 = '0;
      s16 = 1'b0; m16 = '0; op16 = '0; a16 = '0;
      #1;
      check_eq("rst_busy32", 32'(busy32), 32'd0);
      check_eq("rst_done32", 32'(done32), 32'd0);
      check_eq("rst_res32", res32, 32'd0);
      check_eq("rst_busy16", 32'(busy16), 32'd0);
      check_eq("rst_done16", 32'(done16), 32'd0);
      check_eq("rst_res16", 32'(res16), 32'd0);
      repeat (3) @(posedge clk);
      #2 clear_n = 1'b1;

      run32("ror1_a", 3'd3, 32'h0000_0001, 5'd1, 0);
      run32("ror1_b", 3'd3, 32'h8000_0000, 5'd1, 0);
      run32("ror1_c", 3'd3, 32'h1234_5678, 5'd1, 0);
      run32("rol4", 3'd4, 32'h8000_0001, 5'd4, 0);
      run32("shl4", 3'd2, 32'h8000_0001, 5'd4, 0);
      run32("shra31", 3'd1, 32'h8000_0000, 5'd31, 0);
      run32("shr31", 3'd0, 32'h8000_0000, 5'd31, 0);
      run32("shr0", 3'd0, 32'hDEAD_BEEF, 5'd0, 0);
      run32("pass7", 3'd7, 32'hDEAD_BEEF, 5'd7, 0);
      run32("ign_start", 3'd3, 32'h1234_5678, 5'd8, 2);

      do_op16(3'd3, 16'h1234, 4'd9, r16, l16, b16, p16);
      check_eq("ror9_16_res", 32'(r16), 32'h0000_1A09);
      check_eq("ror9_16_lat", l16, 4);

      // Abort: clear mid-shift, outputs must drop without a clock edge.
      @(posedge clk); #1;
      s32 = 1'b1; m32 = 3'd0; op32 = 32'hFFFF_0000; a32 = 5'd20;
      @(posedge clk); #1;
      s32 = 1'b0;
      repeat (5) @(posedge clk);
      #3 clear_n = 1'b0;
      #1;
      check_eq("clr_busy", 32'(busy32), 32'd0);
      check_eq("clr_done", 32'(done32), 32'd0);
      check_eq("clr_res", res32, 32'd0);
      @(posedge clk);
      #2 clear_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done32 === 1'b1 || busy32 === 1'b1) seen++;
      end
      check_eq("clr_no_done", seen, 0);
      run32("after_clr", 3'd4, 32'hCAFE_F00D, 5'd13, 0);

      for (int i = 0; i < 30; i++) begin
         run32($sformatf("r32_%0d", i), 3'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 31)), 0);
      end
      for (int i = 0; i < 30; i++) begin
         run16($sformatf("r16_%0d", i), 3'($urandom_range(0, 7)), 16'($urandom),
               4'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
